// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS halt/resume control block.
// Holds the controller state encoding and the default halt service code.
package mips_ctrl_pkg;

  // Controller state encoding (RUN / HALT / STEP)
  typedef logic [1:0] state_t;

  localparam state_t ST_RUN  = 2'd0;
  localparam state_t ST_HALT = 2'd1;
  localparam state_t ST_STEP = 2'd2;

  // $v0 service code that requests a CPU halt
  localparam logic [31:0] DEFAULT_HALT_CODE = 32'd10;

  // True when a syscall is executing with the halt service code in $v0.
  // Full 32-bit compare: codes differing only in upper bits must not halt.
  function automatic logic is_halt_call(input logic        syscall_t,
                                        input logic [31:0] code,
                                        input logic [31:0] halt_code);
    return syscall_t && (code == halt_code);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Push-button / switch conditioner: two-flop synchroniser followed by an
// edge flop. Produces the synchronised level and a one-cycle pulse per
// rising edge. All flops clear asynchronously on rst.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchroniser chain plus previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;
  // Held button produces a single pulse: prev catches up one cycle later
  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/halt_ctrl.sv
// CPU halt/resume controller.
// A syscall with $v0 == HALT_CODE stops the CPU after that syscall retires;
// a press of the go button resumes it. run_en gates PC/pipeline writes.
// Optional single-step support is compiled in with `define STEP_MODE_EN:
// the step_mode switch then forces HALT from RUN, and each go press from
// HALT runs exactly one cycle (STEP) before halting again.
module halt_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_CODE = DEFAULT_HALT_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_t,
  input  logic [31:0] A,
  input  logic        go,
  input  logic        step_mode,
  output logic        run_en,
  output logic        halted,
  output logic [31:0] halt_cnt
);

  state_t state;
  state_t state_next;

  logic halt_hit;
  logic go_level_unused;
  logic go_edge;
  logic step_sync;
  logic enter_halt;

  // Resume button: synchronise and reduce to one pulse per press
  btn_sync u_go_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (go),
    .level (go_level_unused),
    .pulse (go_edge)
  );

`ifdef STEP_MODE_EN
  logic step_pulse_unused;

  // Single-step switch: only its synchronised level is used
  btn_sync u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_mode),
    .level (step_sync),
    .pulse (step_pulse_unused)
  );
`else
  logic unused_step_mode;

  assign unused_step_mode = step_mode;
  assign step_sync        = 1'b0;
`endif

  assign halt_hit = is_halt_call(syscall_t, A, HALT_CODE);

  // Next-state logic; halt_hit is only looked at while the CPU advances
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        // halt_hit outranks a simultaneous go_edge, which is simply dropped
        if (halt_hit || step_sync) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (go_edge) begin
          state_next = step_sync ? ST_STEP : ST_RUN;
        end
      end
      ST_STEP: begin
        // One advancing cycle only; a halt syscall here lands in the same HALT
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign enter_halt = (state_next == ST_HALT) && (state != ST_HALT);

  // State register with registered Moore outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      run_en <= 1'b1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      run_en <= (state_next != ST_HALT);
      halted <= (state_next == ST_HALT);
    end
  end

  // Count of HALT entries; wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_cnt <= 32'd0;
    end else if (enter_halt) begin
      halt_cnt <= halt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl. A behavioural model tracks the CPU
// mode from the stated rules: go is seen as a press two edges after it was
// sampled high (having been low the edge before), step_mode is seen two
// edges late, halts are counted as they happen.
module tb_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_t;
  logic [31:0] A;
  logic        go;
  logic        step_mode;
  logic        run_en;
  logic        halted;
  logic [31:0] halt_cnt;

  int errors = 0;
  int checks = 0;

`ifdef STEP_MODE_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  typedef enum int {M_RUN, M_HALT, M_STEP} mode_t;

  mode_t       m_mode;
  logic [31:0] m_cnt;
  logic [3:0]  g_hist;  // [k] = go sampled k edges ago (0 = this edge)
  logic [3:0]  s_hist;
  logic [33:0] exp_v;

  always #5 clk = ~clk;

  halt_ctrl #(.HALT_CODE(32'd10)) dut (
    .clk       (clk),
    .rst       (rst),
    .syscall_t (syscall_t),
    .A         (A),
    .go        (go),
    .step_mode (step_mode),
    .run_en    (run_en),
    .halted    (halted),
    .halt_cnt  (halt_cnt)
  );

  task automatic model_reset();
    m_mode = M_RUN;
    m_cnt  = 32'd0;
    g_hist = 4'd0;
    s_hist = 4'd0;
  endtask

  // Advance the model by one rising edge using the inputs present at it
  task automatic model_edge();
    logic press;
    logic step_on;
    logic hit;
    if (rst) begin
      model_reset();
    end else begin
      g_hist  = {g_hist[2:0], go};
      s_hist  = {s_hist[2:0], step_mode};
      press   = g_hist[2] && !g_hist[3];
      step_on = STEP_EN && s_hist[2];
      hit     = syscall_t && (A == 32'd10);
      case (m_mode)
        M_RUN: if (hit || step_on) begin
          m_mode = M_HALT;
          m_cnt  = m_cnt + 32'd1;
        end
        M_HALT: if (press) m_mode = step_on ? M_STEP : M_RUN;
        default: begin
          m_mode = M_HALT;
          m_cnt  = m_cnt + 32'd1;
        end
      endcase
    end
  endtask

  function automatic logic [33:0] model_out();
    return {m_mode != M_HALT, m_mode == M_HALT, m_cnt};
  endfunction

  task automatic drive(input logic sc, input logic [31:0] a, input logic g, input logic s);
    @(negedge clk);
    syscall_t = sc;
    A         = a;
    go        = g;
    step_mode = s;
  endtask

  task automatic step_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    syscall_t = 1'b0; A = 32'd0; go = 1'b0; step_mode = 1'b0;
    step_edge();
    step_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({run_en, halted, halt_cnt} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got run_en=%b halted=%b cnt=%0d required 1 0 0",
               run_en, halted, halt_cnt);
    end
  endtask

  task automatic test_halt_syscall();
    drive(1'b1, 32'd10, 1'b0, 1'b0);
    #1;
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL halt_cycle_run_en: got %b required 1", run_en);
    end
    step_edge();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if ({run_en, halted, halt_cnt} !== {1'b0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL halt_entry: got run_en=%b halted=%b cnt=%0d required 0 1 1",
               run_en, halted, halt_cnt);
    end
    // syscall while halted is ignored
    drive(1'b1, 32'd10, 1'b0, 1'b0);
    step_edge();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    step_edge();
    checks++;
    if ({run_en, halted, halt_cnt} !== {1'b0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL halt_ignores_syscall: got run_en=%b halted=%b cnt=%0d required 0 1 1",
               run_en, halted, halt_cnt);
    end
  endtask

  task automatic test_non_halt_codes();
    logic [31:0] codes [4];
    logic [31:0] cnt0;
    codes[0] = 32'd34; codes[1] = 32'd11; codes[2] = 32'h8000_000A; codes[3] = 32'h0001_000A;
    do_reset();
    cnt0 = halt_cnt;
    foreach (codes[i]) begin
      drive(1'b1, codes[i], 1'b0, 1'b0);
      step_edge();
      checks++;
      if ({run_en, halted, halt_cnt} !== {1'b1, 1'b0, cnt0}) begin
        errors++;
        $display("FAIL non_halt_code_%h: got run_en=%b halted=%b cnt=%0d required 1 0 %0d",
                 codes[i], run_en, halted, halt_cnt, cnt0);
      end
    end
    // halt code without syscall_t must not halt either
    drive(1'b0, 32'd10, 1'b0, 1'b0);
    step_edge();
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL code_without_syscall: got run_en=%b required 1", run_en);
    end
  endtask

  task automatic test_go_latency();
    int rise_at;
    int leaves;
    logic was_halted;
    do_reset();
    drive(1'b1, 32'd10, 1'b0, 1'b0);
    step_edge();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      step_edge();
    end
    rise_at = 0;
    leaves = 0;
    was_halted = halted;
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 32'd0, (i <= 5), 1'b0);
      step_edge();
      if (rise_at == 0 && run_en === 1'b1) rise_at = i;
      if (was_halted && !halted) leaves++;
      was_halted = halted;
    end
    checks++;
    if (rise_at != 3) begin
      errors++;
      $display("FAIL go_latency: got run_en rise at edge %0d required 3", rise_at);
    end
    checks++;
    if (leaves != 1) begin
      errors++;
      $display("FAIL go_single_resume: got %0d resumes required 1", leaves);
    end
    // Hold go in RUN, halt while still held, then keep holding: no resume
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      step_edge();
    end
    drive(1'b1, 32'd10, 1'b1, 1'b0);
    step_edge();
    leaves = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      step_edge();
      if (run_en !== 1'b0) leaves++;
    end
    checks++;
    if (leaves != 0) begin
      errors++;
      $display("FAIL go_hold_no_retrigger: got %0d run cycles required 0", leaves);
    end
    checks++;
    exp_v = model_out();
    if ({run_en, halted, halt_cnt} !== exp_v) begin
      errors++;
      $display("FAIL go_hold_model: got %h required %h", {run_en, halted, halt_cnt}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cnt0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      step_edge();
    end
    cnt0 = halt_cnt;
    // go rises before e1; its pulse meets the halting syscall at e3
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step_edge();
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step_edge();
    drive(1'b1, 32'd10, 1'b1, 1'b0);
    step_edge();
    checks++;
    if ({run_en, halted, halt_cnt} !== {1'b0, 1'b1, cnt0 + 32'd1}) begin
      errors++;
      $display("FAIL halt_beats_go: got run_en=%b halted=%b cnt=%0d required 0 1 %0d",
               run_en, halted, halt_cnt, cnt0 + 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'd0, (i >= 3), 1'b0);
      step_edge();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      step_edge();
    end
    checks++;
    if ({run_en, halted, halt_cnt} !== {1'b1, 1'b0, cnt0 + 32'd1}) begin
      errors++;
      $display("FAIL resume_after_tie: got run_en=%b halted=%b cnt=%0d required 1 0 %0d",
               run_en, halted, halt_cnt, cnt0 + 32'd1);
    end
  endtask

  task automatic test_step_mode();
    int run_cycles;
    logic [31:0] cnt0;
    do_reset();
    cnt0 = halt_cnt;
`ifdef STEP_MODE_EN
    // Synced step_mode forces HALT from RUN
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      step_edge();
    end
    checks++;
    if ({halted, halt_cnt} !== {1'b1, cnt0 + 32'd1}) begin
      errors++;
      $display("FAIL step_enter_halt: got halted=%b cnt=%0d required 1 %0d",
               halted, halt_cnt, cnt0 + 32'd1);
    end
    run_cycles = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b0, 32'd0, (i < 2), 1'b1);
        step_edge();
        if (run_en === 1'b1) run_cycles++;
      end
    end
    checks++;
    if (run_cycles != 3) begin
      errors++;
      $display("FAIL step_cycles: got %0d run cycles required 3", run_cycles);
    end
    checks++;
    if (halt_cnt !== cnt0 + 32'd4) begin
      errors++;
      $display("FAIL step_count: got %0d required %0d", halt_cnt, cnt0 + 32'd4);
    end
`else
    drive(1'b1, 32'd10, 1'b0, 1'b1);
    step_edge();
    run_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'd0, (i < 2), 1'b1);
      step_edge();
      if (run_en === 1'b1) run_cycles++;
    end
    // resume lands after edge 3 and RUN persists despite step_mode
    checks++;
    if (run_cycles != 10) begin
      errors++;
      $display("FAIL step_ignored_run: got %0d run cycles required 10", run_cycles);
    end
    checks++;
    if (halt_cnt !== cnt0 + 32'd1) begin
      errors++;
      $display("FAIL step_ignored_count: got %0d required %0d", halt_cnt, cnt0 + 32'd1);
    end
`endif
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    drive(1'b1, 32'd10, 1'b0, 1'b0);
    step_edge();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    step_edge();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_halt: got halted=%b required 1", halted);
    end
    #2;
    rst = 1'b1;
    go  = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({run_en, halted, halt_cnt} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: got run_en=%b halted=%b cnt=%0d required 1 0 0",
               run_en, halted, halt_cnt);
    end
    step_edge();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      step_edge();
      if ({run_en, halted, halt_cnt} !== {1'b1, 1'b0, 32'd0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL go_held_through_reset: got %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_random();
    logic        sc;
    logic [31:0] a;
    logic        g;
    logic        s;
    int          hold;
    do_reset();
    g = 1'b0; s = 1'b0; hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        g    = $urandom_range(0, 1);
        hold = $urandom_range(1, 8);
        if ($urandom_range(0, 9) == 0) s = ~s;
      end
      hold--;
      sc = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: a = 32'd10;
        1: a = 32'd11;
        2: a = 32'd10 ^ (32'd1 << $urandom_range(4, 31));
        default: a = $urandom;
      endcase
      drive(sc, a, g, s);
      step_edge();
      exp_v = model_out();
      checks++;
      if ({run_en, halted, halt_cnt} !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d: got run_en=%b halted=%b cnt=%0d required %b %b %0d",
                 i, run_en, halted, halt_cnt, exp_v[33], exp_v[32], exp_v[31:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    syscall_t = 1'b0;
    A = 32'd0;
    go = 1'b0;
    step_mode = 1'b0;
    model_reset();
    test_reset();
    test_halt_syscall();
    test_non_halt_codes();
    test_go_latency();
    test_back_to_back();
    test_step_mode();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter: HALT_CODE, default 10, syscall service code ($v0) that halts the CPU.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: syscall_t  input  1  syscall instruction in execute this cycle.
REQ-005 Port: A  input  32  current $v0 operand presented with the syscall.
REQ-006 Port: go  input  1  raw asynchronous resume push-button, level.
REQ-007 Port: step_mode  input  1  raw asynchronous switch; single-step request (used only under STEP_MODE_EN).
REQ-008 Port: run_en  output  1  CPU advance enable; drives PC/pipeline write enables and the statistic strong_halt input.
REQ-009 Port: halted  output  1  high while state is HALT.
REQ-010 Port: halt_cnt  output  32  number of HALT entries since reset.

Function
REQ-011 FSM states: RUN, HALT, STEP; run_en = (state==RUN or state==STEP), Moore output, no combinational path from any input.
REQ-012 halt_hit = syscall_t and (A == HALT_CODE), full 32-bit compare, evaluated only in RUN and STEP.
REQ-013 RUN: halt_hit -> HALT on next edge; the halting syscall cycle itself has run_en=1 (it retires, and resume continues after it).
REQ-014 go path: two-flop synchroniser then edge flop; go_edge = sync2 and not prev, one-cycle pulse per press.
REQ-015 Latency: go rising before edge e1 -> go_edge high between e2 and e3 -> state leaves HALT at e3; run_en high after e3.
REQ-016 HALT: go_edge -> RUN (or STEP, per REQ-022); all other inputs ignored, including syscall_t.
REQ-017 go_edge in RUN or STEP ignored; holding go never repeats the transition.
REQ-018 Simultaneous halt_hit and go_edge in RUN: halt_hit wins, state -> HALT, go_edge discarded.
REQ-019 halt_cnt increments by 1 on every transition into HALT, from RUN or STEP; wraps 0xFFFFFFFF -> 0.
REQ-020 halted = (state==HALT), registered.

Reset
REQ-021 On rst: state=RUN, run_en=1, halted=0, halt_cnt=0, all synchroniser and edge flops=0; asserting rst mid-HALT or mid-STEP returns to RUN immediately, without waiting for clk. If go is held through reset release, the resulting go_edge arrives in RUN and is ignored.

Configuration
REQ-022 With STEP_MODE_EN defined:
- step_mode passes through its own two-flop synchroniser.
- RUN with synced step_mode=1 -> HALT next edge (counted in halt_cnt).
- HALT with go_edge and step_mode=1 -> STEP.
- STEP lasts exactly one cycle (run_en=1), then -> HALT, counted in halt_cnt.
- halt_hit in STEP also -> HALT, with a single halt_cnt increment.
REQ-023 Without STEP_MODE_EN: step_mode is unused; STEP is unreachable; HALT with go_edge -> RUN only.

Structure
REQ-024 Shared package mips_ctrl_pkg holds the state enum (RUN/HALT/STEP) and the default halt code constant (10).
REQ-025 One sub-module btn_sync (2-flop synchroniser, edge flop, asynchronous reset to 0, pulse output); instantiated for go; step_mode uses its synchronised level only.

Verification
REQ-026 Reset, then syscall_t=1 with A=10 for one cycle -> run_en 1 in that cycle, 0 from next edge; halted=1; halt_cnt=1.
REQ-027 Syscall with A=34 or A=11 in RUN -> no state change, run_en stays 1, halt_cnt unchanged.
REQ-028 In HALT, go pulsed high for 5 cycles -> exactly one transition to RUN, run_en rises 3 edges after go rises; holding go for 100 cycles does not re-trigger.
REQ-029 syscall A=10 in the same cycle as a go_edge in RUN -> HALT, halt_cnt +1; later go press -> RUN.
REQ-030 STEP_MODE_EN, step_mode=1, 3 go presses from HALT -> 3 single cycles of run_en=1, halt_cnt +3; no macro -> step_mode ignored and go yields RUN.
REQ-031 rst asserted between clk edges while halted -> run_en=1 and halt_cnt=0 before the next clk edge.
